// File: rtl/io_out_fifo.sv
// rtl/io_out_fifo.sv - processor IO output FIFO with valid/ready drain and sticky overflow
module io_out_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     io_wr_en,
    input  logic [DATA_W-1:0]        io_wr_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    assign full      = (level == CNT_W'(DEPTH));
    assign empty     = (level == '0);
    assign out_valid = ~empty;
    // Masked so the port reads zero after reset even though storage is never cleared.
    assign out_data  = empty ? '0 : mem[rd_ptr];

    assign pop  = out_valid & out_ready;
    assign push = io_wr_en & (~full | pop);

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= io_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + CNT_W'(1);
                2'b01:   level <= level - CNT_W'(1);
                default: level <= level;
            endcase
            if (io_wr_en && !push) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule
